// File: rtl/lif_array_arb.sv
// Leaky integrate-and-fire neuron array with per-neuron event FIFOs, refractory timers and a
// round-robin spike serialiser. Optional macro LIF_SPIKE_COUNT_EN adds per-neuron spike counters.
module lif_array_arb #(
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned VMEM_W      = 16,
  parameter int unsigned NEURON_ID_W = 4,
  parameter int unsigned LEAK_SHIFT  = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned REFRACT_W   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           scan_start_en,
  input  logic [NUM_NEURONS-1:0]         score_valid,
  input  logic [NUM_NEURONS*SCORE_W-1:0] score_in,
  output logic [NUM_NEURONS-1:0]         score_ready,
  input  logic [NUM_NEURONS*VMEM_W-1:0]  thresholds,
  input  logic [REFRACT_W-1:0]           refract_cycles,
`ifdef LIF_SPIKE_COUNT_EN
  input  logic                           spike_count_clr,
  output logic [NUM_NEURONS*16-1:0]      spike_count,
`endif
  output logic                           spike_valid,
  output logic [NEURON_ID_W-1:0]         spike_id,
  input  logic                           spike_ready
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [SCORE_W-1:0]     fifo_mem_q [NUM_NEURONS][FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q   [NUM_NEURONS];
  logic [PtrW-1:0]        rd_ptr_q   [NUM_NEURONS];
  logic [CntW-1:0]        cnt_q      [NUM_NEURONS];
  logic [VMEM_W-1:0]      vmem_q     [NUM_NEURONS];
  logic [VMEM_W-1:0]      vmem_d     [NUM_NEURONS];
  logic [REFRACT_W-1:0]   refr_q     [NUM_NEURONS];
  logic [REFRACT_W-1:0]   refr_d     [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] pending_q, pending_d;
  logic [NUM_NEURONS-1:0] push, pop, accept_vec, eligible, upper, pick;
  logic [NEURON_ID_W-1:0] ptr_q, ptr_d, grant;
  logic                   grant_found, load;
  logic                   spike_valid_q;
  logic [NEURON_ID_W-1:0] spike_id_q;

  assign spike_valid = spike_valid_q;
  assign spike_id    = spike_id_q;

  assign accept_vec = (spike_valid_q & spike_ready) ?
                      (NUM_NEURONS'(1) << spike_id_q) : '0;

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_neuron
    logic [VMEM_W-1:0] thr, leak, add, vnext;
    logic [VMEM_W:0]   sum;
    logic              add_en, fire;

    assign score_ready[g] = (cnt_q[g] != CntW'(FIFO_DEPTH));
    assign push[g]        = score_valid[g] & score_ready[g];
    // A pending neuron holds its queue so at most one spike per neuron is outstanding.
    assign pop[g]         = (cnt_q[g] != '0) & ~pending_q[g];

    assign thr    = thresholds[g*VMEM_W +: VMEM_W];
    assign leak   = scan_start_en ? (vmem_q[g] >> LEAK_SHIFT) : '0;
    assign add_en = pop[g] & (refr_q[g] == '0);
    assign add    = add_en ? VMEM_W'(fifo_mem_q[g][rd_ptr_q[g]]) : '0;
    assign sum    = {1'b0, vmem_q[g] - leak} + {1'b0, add};
    assign vnext  = sum[VMEM_W] ? '1 : sum[VMEM_W-1:0];
    assign fire   = add_en & (thr != '0) & (vnext >= thr);

    assign vmem_d[g]    = fire ? '0 : vnext;
    assign pending_d[g] = fire | (pending_q[g] & ~accept_vec[g]);
    assign refr_d[g]    = accept_vec[g]      ? refract_cycles :
                          (refr_q[g] != '0) ? refr_q[g] - 1'b1 : '0;
  end

  // Round-robin: prefer eligible neurons at or above ptr, otherwise wrap to the lowest one.
  assign eligible    = pending_q & ~accept_vec;
  assign upper       = eligible & ({NUM_NEURONS{1'b1}} << ptr_q);
  assign pick        = (|upper) ? upper : eligible;
  assign grant_found = |eligible;
  assign load        = ~spike_valid_q | spike_ready;

  always_comb begin
    grant = '0;
    for (int k = NUM_NEURONS - 1; k >= 0; k--) begin
      if (pick[k]) grant = NEURON_ID_W'(k);
    end
  end

  assign ptr_d = (grant == NEURON_ID_W'(NUM_NEURONS - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_valid_q <= 1'b0;
      spike_id_q    <= '0;
      ptr_q         <= '0;
      pending_q     <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        vmem_q[i]   <= '0;
        refr_q[i]   <= '0;
      end
    end else begin
      pending_q <= pending_d;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        vmem_q[i] <= vmem_d[i];
        refr_q[i] <= refr_d[i];
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        cnt_q[i] <= cnt_q[i] + CntW'(push[i]) - CntW'(pop[i]);
      end
      if (load) begin
        spike_valid_q <= grant_found;
        if (grant_found) begin
          spike_id_q <= grant;
          ptr_q      <= ptr_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (push[i]) fifo_mem_q[i][wr_ptr_q[i]] <= score_in[i*SCORE_W +: SCORE_W];
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0] spike_cnt_q [NUM_NEURONS];

  always_ff @(posedge clk) begin
    if (rst || spike_count_clr) begin
      for (int i = 0; i < NUM_NEURONS; i++) spike_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (accept_vec[i] && (spike_cnt_q[i] != 16'hFFFF)) spike_cnt_q[i] <= spike_cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_cnt_out
    assign spike_count[g*16 +: 16] = spike_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_lif_array_arb.sv
// Scoreboarded bench for lif_array_arb: a queue-based reference model predicts spike order,
// spike_valid and score_ready; a negedge monitor checks every presented spike against it.
module tb_lif_array_arb;

  localparam int N     = 16;
  localparam int SW    = 4;
  localparam int VW    = 16;
  localparam int IW    = 4;
  localparam int LS    = 4;
  localparam int DEPTH = 4;
  localparam int RW    = 4;
  localparam int VMAX  = (1 << VW) - 1;

  logic            clk;
  logic            rst;
  logic            scan_start_en;
  logic [N-1:0]    score_valid;
  logic [N*SW-1:0] score_in;
  logic [N-1:0]    score_ready;
  logic [N*VW-1:0] thresholds;
  logic [RW-1:0]   refract_cycles;
  logic            spike_valid;
  logic [IW-1:0]   spike_id;
  logic            spike_ready;
`ifdef LIF_SPIKE_COUNT_EN
  logic            spike_count_clr;
  logic [N*16-1:0] spike_count;
`endif

  lif_array_arb #(
    .NUM_NEURONS(N), .SCORE_W(SW), .VMEM_W(VW), .NEURON_ID_W(IW),
    .LEAK_SHIFT(LS), .FIFO_DEPTH(DEPTH), .REFRACT_W(RW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .scan_start_en (scan_start_en),
    .score_valid   (score_valid),
    .score_in      (score_in),
    .score_ready   (score_ready),
    .thresholds    (thresholds),
    .refract_cycles(refract_cycles),
`ifdef LIF_SPIKE_COUNT_EN
    .spike_count_clr(spike_count_clr),
    .spike_count   (spike_count),
`endif
    .spike_valid   (spike_valid),
    .spike_id      (spike_id),
    .spike_ready   (spike_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int mq [N][$];
  int mv [N];
  int mrefr [N];
  bit mpend [N];
  int mptr;
  bit mvalid;
  int mid;
  int exp_q [$];
  bit was_rst;

  task automatic model_edge();
    bit acc, found, fire, rdy;
    int acc_id, g, j, nv, s, t;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mq[i].delete();
        mv[i] = 0; mrefr[i] = 0; mpend[i] = 0;
      end
      mptr = 0; mvalid = 0; mid = 0;
      exp_q.delete();
      return;
    end
    acc    = mvalid && spike_ready;
    acc_id = mid;
    if (!mvalid || spike_ready) begin
      found = 0; g = 0;
      for (int k = 0; k < N; k++) begin
        j = (mptr + k) % N;
        if (!found && mpend[j] && !(acc && j == acc_id)) begin found = 1; g = j; end
      end
      if (found) begin
        mvalid = 1; mid = g; mptr = (g + 1) % N;
        exp_q.push_back(g);
      end else begin
        mvalid = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      rdy  = mq[i].size() < DEPTH;
      t    = int'(thresholds[i*VW +: VW]);
      nv   = mv[i] - (scan_start_en ? (mv[i] >> LS) : 0);
      fire = 0;
      if (mq[i].size() > 0 && !mpend[i]) begin
        s = mq[i].pop_front();
        if (mrefr[i] == 0) begin
          nv = nv + s;
          if (nv > VMAX) nv = VMAX;
          if (t != 0 && nv >= t) begin fire = 1; nv = 0; end
        end
      end
      if (acc && acc_id == i) begin
        mpend[i] = 0; mrefr[i] = int'(refract_cycles);
      end else if (mrefr[i] > 0) begin
        mrefr[i]--;
      end
      if (fire) mpend[i] = 1;
      mv[i] = nv;
      if (score_valid[i] && rdy) mq[i].push_back(int'(score_in[i*SW +: SW]));
    end
  endtask

  task automatic check_after();
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) exp_rdy[i] = (mq[i].size() < DEPTH);
    n_vec++;
    if (spike_valid !== mvalid) begin
      n_err++;
      $display("FAIL spike_valid @%0t: got %b, required %b", $time, spike_valid, mvalid);
    end
    n_vec++;
    if (score_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL score_ready @%0t: got %h, required %h", $time, score_ready, exp_rdy);
    end
    if (was_rst) begin
      n_vec++;
      if (spike_id !== '0) begin
        n_err++;
        $display("FAIL reset_spike_id @%0t: got %0d, required 0", $time, spike_id);
      end
    end
  endtask

  task automatic step();
    was_rst = rst;
    model_edge();
    @(posedge clk);
    #1;
    check_after();
  endtask

  task automatic idle(int n);
    score_valid = '0;
    repeat (n) step();
  endtask

  task automatic push1(int i, int s);
    score_valid = '0;
    score_valid[i] = 1'b1;
    score_in[i*SW +: SW] = SW'(s);
    step();
    score_valid = '0;
  endtask

  task automatic set_thr(int i, int t);
    thresholds[i*VW +: VW] = VW'(t);
  endtask

  // Monitor: every presented spike must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && spike_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL spike_id @%0t: got %0d, required no spike", $time, spike_id);
      end else begin
        if (int'(spike_id) != exp_q[0]) begin
          n_err++;
          $display("FAIL spike_id @%0t: got %0d, required %0d", $time, spike_id, exp_q[0]);
        end
        if (spike_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; scan_start_en = 1'b0; score_valid = '0; score_in = '0;
    thresholds = '0; refract_cycles = '0; spike_ready = 1'b1;
`ifdef LIF_SPIKE_COUNT_EN
    spike_count_clr = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    idle(2);

    // Single fire on neuron 0
    set_thr(0, 5);
    push1(0, 5);
    idle(5);

    // Leak: build v=160 on neuron 1 (disabled), leak to 150, then probe 151 / 152
    repeat (10) push1(1, 15);
    push1(1, 10);
    idle(6);
    scan_start_en = 1'b1; step(); scan_start_en = 1'b0;
    idle(2);
    set_thr(1, 152);
    push1(1, 1);
    idle(3);
    push1(1, 1);
    idle(5);
    set_thr(1, 0);

    // Round-robin under backpressure
    set_thr(3, 2); set_thr(7, 2); set_thr(12, 2);
    spike_ready = 1'b0;
    score_valid = '0;
    score_valid[3] = 1'b1; score_valid[7] = 1'b1; score_valid[12] = 1'b1;
    score_in[3*SW +: SW] = 4'd2; score_in[7*SW +: SW] = 4'd2; score_in[12*SW +: SW] = 4'd2;
    step();
    idle(7);
    spike_ready = 1'b1;
    idle(6);

    // FIFO full while neuron 2 is pending
    set_thr(2, 1);
    spike_ready = 1'b0;
    push1(2, 1);
    idle(3);
    repeat (6) push1(2, 1);
    spike_ready = 1'b1;
    idle(12);

    // Refractory period of 3
    refract_cycles = 4'd3;
    set_thr(5, 1);
    repeat (14) push1(5, 1);
    idle(10);
    refract_cycles = '0;

    // Randomised traffic
    for (int i = 0; i < N; i++) set_thr(i, ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(40, 1));
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 0) refract_cycles = RW'($urandom_range(3, 0));
      for (int i = 0; i < N; i++) score_valid[i] = ($urandom_range(3, 0) == 0);
      score_in      = {$urandom, $urandom};
      scan_start_en = ($urandom_range(31, 0) == 0);
      spike_ready   = ($urandom_range(3, 0) != 0);
      step();
    end
    scan_start_en = 1'b0; refract_cycles = '0; spike_ready = 1'b1;
    idle(20);

    // Reset mid-operation with queued events and a held spike
    for (int i = 0; i < N; i++) set_thr(i, 1);
    spike_ready = 1'b0;
    score_valid = '1;
    for (int i = 0; i < N; i++) score_in[i*SW +: SW] = 4'd1;
    repeat (3) step();
    score_valid = '0;
    rst = 1'b1; step();
    rst = 1'b0;
    spike_ready = 1'b1;
    idle(10);

    // Saturation on a disabled neuron, then arm it at full scale with a zero score
    thresholds = '0;
    score_in = '0;
    score_valid[4] = 1'b1;
    score_in[4*SW +: SW] = 4'd15;
    repeat (4400) step();
    score_valid = '0;
    idle(6);
    set_thr(4, VMAX);
    push1(4, 0);
    idle(6);

    idle(30);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d spikes still expected, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
